bcd_modulo_counter: RTL and testbench
=====================================

BCD_MODULO_COUNTER -- requirements
Module: bcd_modulo_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, number of BCD digits (1..4).
REQ-002 The block SHALL have parameter MODULUS, default 60, count range 0..MODULUS-1 (2 <= MODULUS <= 10^DIGITS).
REQ-003 The block SHALL have parameter EDGE_SRC, default 1; 1 = tick is a level source counted on its falling edge, 0 = tick is a one-cycle strobe.
REQ-004 The block SHALL have parameter WRAP, default 1; 1 = wrap at limits, 0 = saturate at limits.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 tick  input  1  count source (level or strobe per EDGE_SRC).
REQ-008 enable  input  1  count enable; 0 drops count events.
REQ-009 up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-010 clear  input  1  synchronous clear to 0.
REQ-011 load  input  1  synchronous load of load_bcd.
REQ-012 load_bcd  input  4*DIGITS  load value; digit 0 in bits [3:0].
REQ-013 bcd  output  4*DIGITS  registered count; digit 0 in bits [3:0].
REQ-014 carry  output  1  registered one-cycle pulse on wrap (up MODULUS-1->0, down 0->MODULUS-1).
REQ-015 load_err  output  1  registered one-cycle pulse on rejected load value.
REQ-016 at_zero  output  1  combinational, bcd == 0.
REQ-017 at_max  output  1  combinational, bcd == MODULUS-1.

Function
REQ-018 With EDGE_SRC=1, tick SHALL be registered each cycle (tick_d), and a count event SHALL occur on the cycle where tick_d=1 and tick=0.
REQ-019 With EDGE_SRC=0, a count event SHALL occur on every cycle where tick=1.
REQ-020 On a count event with enable=1, bcd SHALL take its new value at that same rising edge (latency 1 clk from event sampling).
REQ-021 Priority SHALL be clear > load > count event; a lower-priority event in the same cycle is dropped, not queued.
REQ-022 Events with enable=0 SHALL be dropped; tick_d still tracks tick.
REQ-023 Increment SHALL be a decimal ripple: digit 9 -> 0 with carry into the next digit; digits never hold values above 9.
REQ-024 Decrement SHALL be a decimal ripple: digit 0 -> 9 with borrow from the next digit.
REQ-025 Up at MODULUS-1: WRAP=1 -> bcd=0 and carry=1 for one cycle; WRAP=0 -> bcd unchanged, carry=0.
REQ-026 Down at 0: WRAP=1 -> bcd=MODULUS-1 and carry=1 for one cycle; WRAP=0 -> bcd unchanged, carry=0.
REQ-027 carry SHALL be 0 on every cycle without a wrap, including clear and load cycles.
REQ-028 Load of a value with any digit > 9, or with value >= MODULUS, SHALL set bcd=MODULUS-1 and pulse load_err for one cycle.
REQ-029 A valid load SHALL set bcd=load_bcd with load_err=0.
REQ-030 Direction SHALL be sampled per event; an up_dn change between events takes effect on the next event.

Reset
REQ-031 When reset_n=0 at a rising clk edge: bcd=0, carry=0, load_err=0, tick_d=0; reset_n overrides clear, load and tick.
REQ-032 Reset mid-count SHALL discard any event in that cycle; a tick held high across reset release SHALL be counted on its next falling edge only.

Verification
REQ-033 DIGITS=2, MODULUS=60, EDGE_SRC=1, WRAP=1: 60 falling edges of tick from 0 -> bcd reaches 59 after 59 edges, then 00 with carry high for exactly 1 cycle.
REQ-034 Same config, up_dn=0 from 00: one event -> bcd=59, carry pulse; next event -> 58, no carry.
REQ-035 WRAP=0: load 59, up event -> stays 59, carry=0; load 00, down event -> stays 00.
REQ-036 load_bcd=8'h7A, then 8'h65 -> bcd=59 with load_err pulse each time; load_bcd=8'h42 -> bcd=42, load_err=0.
REQ-037 Same-cycle clear, load=8'h30 and count event at bcd=25 -> bcd=00, carry=0; load with event and no clear -> bcd=30.
REQ-038 reset_n low while bcd=37 and tick falling -> next cycle bcd=00, all pulses 0; EDGE_SRC=0 strobes at DIGITS=3, MODULUS=1000 from 999 -> 000 with carry pulse.

Source files
------------

// File: rtl/bcd_modulo_counter_if.sv
// Signal bundle for bcd_modulo_counter: count controls, load port and registered count/status.
// The counter is the slave side; the master side drives it and observes the count.
interface bcd_modulo_counter_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  tick;
  logic                  enable;
  logic                  up_dn;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_bcd;
  logic [4*DIGITS-1:0]   bcd;
  logic                  carry;
  logic                  load_err;
  logic                  at_zero;
  logic                  at_max;

  modport master (
    output tick, enable, up_dn, clear, load, load_bcd,
    input  bcd, carry, load_err, at_zero, at_max
  );

  modport slave (
    input  tick, enable, up_dn, clear, load, load_bcd,
    output bcd, carry, load_err, at_zero, at_max
  );
endinterface

// File: rtl/bcd_modulo_counter.sv
// Multi-digit BCD up/down counter with a programmable modulus, wrap or saturate at the limits,
// a validated parallel load and an optional falling-edge detector on the tick source.
module bcd_modulo_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned MODULUS  = 60,
  parameter int unsigned EDGE_SRC = 1,
  parameter int unsigned WRAP     = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  bcd_modulo_counter_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  localparam logic [W-1:0] MaxBcd = to_bcd(MODULUS - 1);

  logic [W-1:0] bcd_q, bcd_d;
  logic         carry_q, carry_d;
  logic         load_err_q, load_err_d;
  logic         tick_q;
  logic         count_ev;
  logic         load_valid;

  assign count_ev = (EDGE_SRC != 0) ? (tick_q & ~bus.tick) : bus.tick;

  // With all digits valid, BCD ordering equals numeric ordering, so a plain compare suffices.
  assign load_valid = digits_ok(bus.load_bcd) && (bus.load_bcd <= MaxBcd);

  always_comb begin
    bcd_d      = bcd_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (bus.clear) begin
      bcd_d = '0;
    end else if (bus.load) begin
      if (load_valid) begin
        bcd_d = bus.load_bcd;
      end else begin
        bcd_d      = MaxBcd;
        load_err_d = 1'b1;
      end
    end else if (count_ev && bus.enable) begin
      if (bus.up_dn) begin
        if (bcd_q == MaxBcd) begin
          if (WRAP != 0) begin
            bcd_d   = '0;
            carry_d = 1'b1;
          end
        end else begin
          bcd_d = bcd_inc(bcd_q);
        end
      end else begin
        if (bcd_q == '0) begin
          if (WRAP != 0) begin
            bcd_d   = MaxBcd;
            carry_d = 1'b1;
          end
        end else begin
          bcd_d = bcd_dec(bcd_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcd_q      <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
      tick_q     <= bus.tick;
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.carry    = carry_q;
  assign bus.load_err = load_err_q;
  assign bus.at_zero  = (bcd_q == '0);
  assign bus.at_max   = (bcd_q == MaxBcd);

endmodule

// File: tb/tb_bcd_modulo_counter.sv
// Scoreboard bench: three counter configurations share one control stream; an integer
// reference model predicts each cycle's outputs and a monitor compares after every edge.
module tb_bcd_modulo_counter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_modulo_counter_if #(.DIGITS(2)) if_a ();
  bcd_modulo_counter_if #(.DIGITS(2)) if_b ();
  bcd_modulo_counter_if #(.DIGITS(3)) if_c ();

  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60), .EDGE_SRC(1), .WRAP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a)
  );
  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60), .EDGE_SRC(1), .WRAP(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b)
  );
  bcd_modulo_counter #(.DIGITS(3), .MODULUS(1000), .EDGE_SRC(0), .WRAP(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        carry;
    logic        err;
    logic        az;
    logic        am;
  } obs_t;

  obs_t q_a[$];
  obs_t q_b[$];
  obs_t q_c[$];

  int checks = 0;
  int errors = 0;

  int cnt[3];
  bit tprev[3];
  int modv[3]     = '{60, 60, 1000};
  int digits_v[3] = '{2, 2, 3};
  bit edge_v[3]   = '{1'b1, 1'b1, 1'b0};
  bit wrap_v[3]   = '{1'b1, 1'b0, 1'b1};

  function automatic logic [15:0] to_bcd16(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  task automatic model_step(input int k, input bit rst, input bit tk, input bit en, input bit up,
                            input bit clr, input bit ld, input logic [15:0] lv, output obs_t e);
    bit ev;
    bit bad;
    int val;
    int d;
    int p;
    e = '0;
    if (!rst) begin
      cnt[k]   = 0;
      tprev[k] = 1'b0;
    end else begin
      ev = edge_v[k] ? (tprev[k] && !tk) : tk;
      tprev[k] = tk;
      if (clr) begin
        cnt[k] = 0;
      end else if (ld) begin
        val = 0;
        bad = 1'b0;
        p   = 1;
        for (int i = 0; i < digits_v[k]; i++) begin
          d = int'((lv >> (4 * i)) & 16'hF);
          if (d > 9) bad = 1'b1;
          val += d * p;
          p   *= 10;
        end
        if (bad || val >= modv[k]) begin
          cnt[k] = modv[k] - 1;
          e.err  = 1'b1;
        end else begin
          cnt[k] = val;
        end
      end else if (ev && en) begin
        if (up) begin
          if (cnt[k] == modv[k] - 1) begin
            if (wrap_v[k]) begin
              cnt[k]  = 0;
              e.carry = 1'b1;
            end
          end else begin
            cnt[k]++;
          end
        end else begin
          if (cnt[k] == 0) begin
            if (wrap_v[k]) begin
              cnt[k]  = modv[k] - 1;
              e.carry = 1'b1;
            end
          end else begin
            cnt[k]--;
          end
        end
      end
    end
    e.bcd = to_bcd16(cnt[k]);
    e.az  = (cnt[k] == 0);
    e.am  = (cnt[k] == modv[k] - 1);
  endtask

  task automatic cyc(input bit rst, input bit tk, input bit en, input bit up, input bit clr,
                     input bit ld, input logic [15:0] lv);
    obs_t e;
    @(negedge clk);
    reset_n = rst;
    if_a.tick = tk; if_a.enable = en; if_a.up_dn = up; if_a.clear = clr; if_a.load = ld;
    if_b.tick = tk; if_b.enable = en; if_b.up_dn = up; if_b.clear = clr; if_b.load = ld;
    if_c.tick = tk; if_c.enable = en; if_c.up_dn = up; if_c.clear = clr; if_c.load = ld;
    if_a.load_bcd = lv[7:0];
    if_b.load_bcd = lv[7:0];
    if_c.load_bcd = lv[11:0];
    model_step(0, rst, tk, en, up, clr, ld, lv, e); q_a.push_back(e);
    model_step(1, rst, tk, en, up, clr, ld, lv, e); q_b.push_back(e);
    model_step(2, rst, tk, en, up, clr, ld, lv, e); q_c.push_back(e);
  endtask

  task automatic pulse(input bit en, input bit up);
    cyc(1'b1, 1'b1, en, up, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, en, up, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got bcd=%h carry=%b load_err=%b at_zero=%b at_max=%b, expected bcd=%h carry=%b load_err=%b at_zero=%b at_max=%b",
               name, $time, act.bcd, act.carry, act.err, act.az, act.am,
               exp.bcd, exp.carry, exp.err, exp.az, exp.am);
    end
  endtask

  // Monitor: every cycle presents a fresh registered output, so one expectation is consumed per edge.
  initial begin
    obs_t act;
    obs_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        exp = q_a.pop_front();
        act.bcd = 16'(if_a.bcd); act.carry = if_a.carry; act.err = if_a.load_err;
        act.az = if_a.at_zero; act.am = if_a.at_max;
        compare("dut_a", act, exp);
      end
      if (q_b.size() > 0) begin
        exp = q_b.pop_front();
        act.bcd = 16'(if_b.bcd); act.carry = if_b.carry; act.err = if_b.load_err;
        act.az = if_b.at_zero; act.am = if_b.at_max;
        compare("dut_b", act, exp);
      end
      if (q_c.size() > 0) begin
        exp = q_c.pop_front();
        act.bcd = 16'(if_c.bcd); act.carry = if_c.carry; act.err = if_c.load_err;
        act.az = if_c.at_zero; act.am = if_c.at_max;
        compare("dut_c", act, exp);
      end
    end
  end

  initial begin
    logic [15:0] lv;
    bit rst, tk, en, up, clr, ld;
    if_a.tick = 0; if_a.enable = 0; if_a.up_dn = 1; if_a.clear = 0; if_a.load = 0; if_a.load_bcd = '0;
    if_b.tick = 0; if_b.enable = 0; if_b.up_dn = 1; if_b.clear = 0; if_b.load = 0; if_b.load_bcd = '0;
    if_c.tick = 0; if_c.enable = 0; if_c.up_dn = 1; if_c.clear = 0; if_c.load = 0; if_c.load_bcd = '0;

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);

    // Full up cycle: 59 after 59 edges, wrap to 00 with a single carry on the 60th.
    repeat (60) pulse(1'b1, 1'b1);
    // Down from 00: wrap to 59 with carry, then 58.
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    // Saturating limits on dut_b.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0059);
    pulse(1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    pulse(1'b1, 1'b0);
    // Rejected and accepted loads.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h007A);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0065);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0042);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    // Priority: clear beats load beats count event.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0025);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0030);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0025);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0030);
    // Reset during a falling tick at 37, then tick held high across reset release.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0037);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    // Strobe-mode wrap 999 -> 000 on dut_c.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0999);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      tk  = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 7) != 0);
      up  = ($urandom_range(0, 3) != 0) ? (n % 200 < 100) : 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) begin
        lv = {4'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        lv = 16'($urandom);
      end
      cyc(rst, tk, en, up, clr, ld, lv);
    end

    repeat (2) @(posedge clk);
    #2;
    if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d/%0d pending expectations, expected 0/0/0",
               q_a.size(), q_b.size(), q_c.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
